// File: rtl/wbc_per_pkg.sv
// Shared definitions for the peripheral-interconnect slaves: bus widths,
// the RAM bridge state encoding and the common address-window decoder.
package wbc_per_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_AW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic {
        BR_IDLE,
        BR_RESP
    } br_state_t;

    // True when the byte address falls inside the window that starts at base
    // and spans 2**(aw+2) bytes; only the bits above the window are compared.
    function automatic logic in_window(input logic [WB_AW-1:0] adr,
                                       input logic [WB_AW-1:0] base,
                                       input int               aw);
        return (adr >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage

// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave driving a single-port RAM with registered read data.
// Every accepted strobe is answered one cycle later, which lines the ack up
// with the RAM's read latency; out-of-window or empty-select accesses get err.
module wb_ram_bridge
    import wbc_per_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [WB_AW-1:0]  BASE_ADDR = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [WB_AW-1:0]    wb_adr_i,
    input  logic [WB_SELW-1:0]  wb_sel_i,
    input  logic [WB_DW-1:0]    wb_dat_i,
    output logic [WB_DW-1:0]    wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                ram_we_o,
    output logic [ADDR_W-1:0]   ram_adr_o,
    output logic [WB_SELW-1:0]  ram_be_o,
    output logic [WB_DW-1:0]    ram_dat_o,
    input  logic [WB_DW-1:0]    ram_dat_i
);

    br_state_t state;
    br_state_t state_next;
    logic      req;
    logic      hit;
    logic      bad;
    logic      resp_err;
    logic      resp_we;

    assign req = wb_cyc_i & wb_stb_i;
    assign hit = in_window(wb_adr_i, BASE_ADDR, ADDR_W);
    assign bad = !hit | (wb_sel_i == '0);

    // The RAM sees the bus address, lanes and data directly; only the write
    // enable is qualified, so reads need no extra register stage.
    assign ram_adr_o = wb_adr_i[ADDR_W+1:2];
    assign ram_be_o  = wb_sel_i;
    assign ram_dat_o = wb_dat_i;

    // State register plus the attributes of the accepted access that the
    // response cycle needs (error flag and direction).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= BR_IDLE;
            resp_err <= 1'b0;
            resp_we  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == BR_IDLE && req) begin
                resp_err <= bad;
                resp_we  <= wb_we_i;
            end
        end
    end

    // Accept in IDLE, answer in RESP; dropping cyc during RESP silently aborts.
    always_comb begin
        state_next = state;
        ram_we_o   = 1'b0;
        wb_ack_o   = 1'b0;
        wb_err_o   = 1'b0;
        wb_dat_o   = '0;
        case (state)
            BR_IDLE: begin
                if (req) begin
                    state_next = BR_RESP;
                end
                ram_we_o = req & wb_we_i & !bad & !rst_i;
            end
            BR_RESP: begin
                state_next = BR_IDLE;
                wb_ack_o   = !resp_err & wb_cyc_i & !rst_i;
                wb_err_o   = resp_err & wb_cyc_i & !rst_i;
                if (wb_ack_o && !resp_we) begin
                    wb_dat_o = ram_dat_i;
                end
            end
            default: begin
                state_next = BR_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Directed bench for wb_ram_bridge with a behavioural registered-read RAM.
module tb_wb_ram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic        ram_we;
    logic [11:0] ram_adr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdat;
    logic [31:0] ram_rdat;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    wb_ram_bridge #(.ADDR_W(12), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_sel_i  (sel),
        .wb_dat_i  (wdat),
        .wb_dat_o  (rdat),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .ram_we_o  (ram_we),
        .ram_adr_o (ram_adr),
        .ram_be_o  (ram_be),
        .ram_dat_o (ram_wdat),
        .ram_dat_i (ram_rdat)
    );

    // Single-port RAM macro: byte-lane writes, read data registered.
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
            end
        end
        ram_rdat <= mem[ram_adr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        adr  = 32'h0;
        sel  = 4'h0;
        wdat = 32'h0;
    endtask

    // One complete access with the strobe held until the response cycle.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        #1;
        check({tag, "_ramwe"}, ram_we, w && !exp_err);
        check({tag, "_ramadr"}, ram_adr, a[13:2]);
        check({tag, "_rambe"}, ram_be, s);
        check({tag, "_ramdat"}, ram_wdat, d);
        check({tag, "_noack_T"}, {err, ack}, 0);
        @(negedge clk);
        #1;
        check({tag, "_ack"}, ack, !exp_err);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_dat"}, rdat, (w || exp_err) ? 32'h0 : exp_rd);
        check({tag, "_ramwe_T1"}, ram_we, 0);
        #1;
        idle_bus();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        rst = 1'b1;
        idle_bus();

        // Reset: a write hit presented during reset must not reach the RAM.
        @(negedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF; wdat = 32'hFFFF_FFFF;
        #1;
        check("rst_ramwe", ram_we, 0);
        check("rst_ack", {err, ack}, 0);
        check("rst_dat", rdat, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        #1;
        check("post_rst_resp", {err, ack}, 0);
        check("post_rst_dat", rdat, 0);

        // Full-word write then read back.
        access("wr10", 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
        access("rd10", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Out-of-window read, empty-select write, out-of-window aliasing write.
        access("oob_rd", 1'b0, 32'h4000, 4'hF, 32'h0, 1'b1, 32'h0);
        access("sel0_wr", 1'b1, 32'h10, 4'h0, 32'h1111_1111, 1'b1, 32'h0);
        access("oob_wr", 1'b1, 32'h4010, 4'hF, 32'h2222_2222, 1'b1, 32'h0);
        access("rd10_kept", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Abort: cyc dropped in the response cycle suppresses the answer.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        #1;
        check("abort_resp", {err, ack}, 0);
        check("abort_dat", rdat, 0);
        access("rd_after_abort", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Single byte lane write over a cleared word.
        access("clr10", 1'b1, 32'h10, 4'hF, 32'h0, 1'b0, 32'h0);
        access("byte11", 1'b1, 32'h11, 4'b0010, 32'h0000_5A00, 1'b0, 32'h0);
        access("rd_byte", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'h0000_5A00);

        // Back-to-back writes with the strobe held for four cycles.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; sel = 4'hF; wdat = 32'hA1A1_A1A1;
        #1;
        check("b2b_c0_ramwe", ram_we, 1);
        check("b2b_c0_ack", ack, 0);
        @(negedge clk);
        #1;
        check("b2b_c1_ack", ack, 1);
        check("b2b_c1_ramwe", ram_we, 0);
        #1;
        adr = 32'h4; wdat = 32'hB2B2_B2B2;
        @(negedge clk);
        #1;
        check("b2b_c2_ramwe", ram_we, 1);
        check("b2b_c2_ack", ack, 0);
        check("b2b_c2_adr", ram_adr, 1);
        @(negedge clk);
        #1;
        check("b2b_c3_ack", ack, 1);
        check("b2b_c3_ramwe", ram_we, 0);
        #1;
        idle_bus();
        access("rd_w0", 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'hA1A1_A1A1);
        access("rd_w1", 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, 32'hB2B2_B2B2);

        // Reset during the response cycle: no answer, but the write stays.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; wdat = 32'h1234_5678;
        #1;
        check("rstmid_ramwe", ram_we, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_resp", {err, ack}, 0);
        check("rstmid_ramwe_T1", ram_we, 0);
        @(negedge clk);
        rst = 1'b0;
        stb = 1'b0;
        #1;
        check("rstmid_after", {err, ack}, 0);
        #1;
        idle_bus();
        access("rd_w8", 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'h1234_5678);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_ram_bridge.md
Name: wb_ram_bridge

Overview:
- Wishbone classic (B3) slave that acts as the initiator on the on-chip single-port RAM port (we/adr/be/dat in, registered dat out).
- Converts CPU/bus transactions into RAM cycles and hides the RAM's 1-cycle registered read latency behind ack timing.
- Decodes its address window and errors out-of-window or empty-select accesses.
- Sits between the peripheral interconnect (wbc_per) and the RAM macro.

Parameters:
ADDR_W, 12, RAM word-address width (4096 words)
BASE_ADDR, 32'h0000_0000, byte base address of the window; compared on bits [31:ADDR_W+2]

Ports:
clk_i  in  1  sole clock, rising edge
rst_i  in  1  reset, synchronous, active-high
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  1=write, 0=read
wb_adr_i  in  32  byte address
wb_sel_i  in  4  byte lane selects, lane n = dat[8n+7:8n]
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
ram_we_o  out  1  RAM write enable
ram_adr_o  out  ADDR_W  RAM word address
ram_be_o  out  4  RAM byte enables
ram_dat_o  out  32  RAM write data
ram_dat_i  in  32  RAM registered read data

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0. ram_we_o=0 in any cycle rst_i=1.
- req = wb_cyc_i & wb_stb_i. hit = (wb_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]). bad = !hit | (wb_sel_i == 0).
- ram_adr_o = wb_adr_i[ADDR_W+1:2], ram_be_o = wb_sel_i, ram_dat_o = wb_dat_i. These are combinational pass-through at all times.
- ram_we_o = req & wb_we_i & !bad & (state==IDLE) & !rst_i.
- wb_adr_i[1:0] is ignored; lane selection comes from wb_sel_i only.
- State machine has 2 states: IDLE and RESP.
  - IDLE, req in cycle T: go to RESP at the edge ending T. Register resp_err=bad.
  - Write hit: the RAM write commits at the edge ending T.
  - Read hit: the RAM samples the address at the edge ending T.
  - Any bad access: the RAM write is suppressed.
  - RESP (cycle T+1):
    - wb_ack_o = !resp_err & wb_cyc_i; wb_err_o = resp_err & wb_cyc_i.
    - wb_dat_o = ram_dat_i on a read ack, else 0.
    - Always returns to IDLE at the end of T+1.
  - ack and err are never both high.
- Latency: exactly 1 cycle from strobe to ack/err for both reads and writes.
- Throughput: 1 transfer per 2 cycles. Back-to-back req in T+2 is accepted normally. A strobe still held in T+1 is not re-accepted.
- Abort: if wb_cyc_i=0 during RESP, ack/err are suppressed and state returns to IDLE. An already-committed write is not undone.
- Reset mid-operation: rst_i in RESP forces IDLE. No ack/err is issued the following cycle. RAM contents are never cleared by reset.
- Read-after-write to the same word returns the new data. The write commits at T, the read samples at T+2.

Decomposition:
- Package wbc_per_pkg holds:
  - localparam WB_DW=32, WB_AW=32, WB_SELW=4
  - typedef enum logic {BR_IDLE, BR_RESP} br_state_t
  - function in_window(adr, base, aw), shared with other peripheral decoders
- No sub-module. A testbench wrapper instantiates wb_ram_bridge plus the RAM macro.

Test Plan:
- Write 32'hDEADBEEF to 0x0000_0010 with sel=4'hF, then read 0x0000_0010 -> ack exactly 1 cycle after stb each time; read wb_dat_o=32'hDEADBEEF.
- Byte write 8'h5A to 0x0000_0011 (sel=4'b0010) over existing 32'h00000000, then read -> 32'h00005A00; other lanes unchanged.
- Read from 0x0000_4000 (outside 16 KiB window, BASE=0) -> wb_err_o=1 one cycle later, wb_ack_o=0, ram_we_o never high. A write with sel=0 -> err, RAM unchanged.
- Back-to-back: stb held high over 4 cycles with writes to words 0 and 1 -> exactly two acks in cycles 1 and 3, both words written, no duplicate write.
- Abort: read strobed, wb_cyc_i dropped in next cycle -> no ack/err. The next read is serviced normally.
- Reset: write accepted, rst_i=1 in RESP cycle -> no ack afterwards, state IDLE. A read of that word returns the written data.
